// File: rtl/clock_pkg.sv
// Shared encodings, key indices, blink masks and time arithmetic for the
// seven-segment clock time-setting controller.
package clock_pkg;

    localparam int unsigned KEY_W      = 5;
    localparam int unsigned K_MODE     = 0;
    localparam int unsigned K_UP       = 1;
    localparam int unsigned K_DOWN     = 2;
    localparam int unsigned K_CANCEL   = 3;
    localparam int unsigned K_RESERVED = 4;

    localparam int unsigned HOUR_W     = 5;
    localparam int unsigned MINSEC_W   = 6;
    localparam int unsigned MASK_W     = 8;
    localparam int unsigned MODE_W     = 2;

    localparam int unsigned HOUR_MAX   = 23;
    localparam int unsigned MINSEC_MAX = 59;

    localparam logic [MASK_W-1:0] MASK_HOUR = 8'b1100_0000;
    localparam logic [MASK_W-1:0] MASK_MIN  = 8'b0001_1000;
    localparam logic [MASK_W-1:0] MASK_SEC  = 8'b0000_0011;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_e;

    typedef struct packed {
        logic [HOUR_W-1:0]   hour;
        logic [MINSEC_W-1:0] min;
        logic [MINSEC_W-1:0] sec;
    } clk_time_t;

    // Modulo up/down step of a field whose range is 0..max.
    function automatic logic [MINSEC_W-1:0] wrap_step(input logic [MINSEC_W-1:0] v,
                                                      input logic [MINSEC_W-1:0] max,
                                                      input logic up);
        if (up) begin
            return (v == max) ? '0 : v + MINSEC_W'(1);
        end
        return (v == '0) ? max : v - MINSEC_W'(1);
    endfunction

    function automatic clk_time_t time_inc(input clk_time_t t);
        clk_time_t r;
        r     = t;
        r.sec = wrap_step(t.sec, MINSEC_W'(MINSEC_MAX), 1'b1);
        if (t.sec == MINSEC_W'(MINSEC_MAX)) begin
            r.min = wrap_step(t.min, MINSEC_W'(MINSEC_MAX), 1'b1);
            if (t.min == MINSEC_W'(MINSEC_MAX)) begin
                r.hour = HOUR_W'(wrap_step(MINSEC_W'(t.hour), MINSEC_W'(HOUR_MAX), 1'b1));
            end
        end
        return r;
    endfunction

    function automatic logic [MASK_W-1:0] field_mask(input mode_e m);
        case (m)
            MODE_SET_HOUR: return MASK_HOUR;
            MODE_SET_MIN:  return MASK_MIN;
            MODE_SET_SEC:  return MASK_SEC;
            default:       return '0;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Key inputs and display-side outputs of the clock time-setting controller.
interface clock_set_ctrl_if;

    logic [clock_pkg::KEY_W-1:0]    key;
    logic [clock_pkg::HOUR_W-1:0]   hour_o;
    logic [clock_pkg::MINSEC_W-1:0] min_o;
    logic [clock_pkg::MINSEC_W-1:0] sec_o;
    logic [clock_pkg::MASK_W-1:0]   blink_mask;
    logic [clock_pkg::MODE_W-1:0]   mode_o;
    logic                           tick_o;

    modport master (output key, input hour_o, min_o, sec_o, blink_mask, mode_o, tick_o);
    modport slave  (input key, output hour_o, min_o, sec_o, blink_mask, mode_o, tick_o);

endinterface

// File: rtl/key_edge_detect.sv
// Rising-edge detector for the debounced key levels.
module key_edge_detect
    import clock_pkg::*;
(
    input  logic             clk,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] press_c
);

    logic [KEY_W-1:0] prev_key;

    // Loads every cycle, reset included, so a key held through reset never looks like a press.
    always_ff @(posedge clk) begin
        prev_key <= key;
    end

    assign press_c = key & ~prev_key;

endmodule

// File: rtl/clock_set_ctrl.sv
// Live time keeping plus RUN/SET_HOUR/SET_MIN/SET_SEC editing FSM with
// per-field blink mask for the display scanner.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned T1S       = 100000000,
    parameter int unsigned BLINK_DIV = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    clock_set_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W   = (T1S > 1)       ? $clog2(T1S)       : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [KEY_W-1:0]   press_c;
    logic               unused_key;

    mode_e              mode_q,      mode_d;
    clk_time_t          live_q,      live_d;
    clk_time_t          edit_q,      edit_d;
    logic [CNT_W-1:0]   sec_cnt_q,   sec_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q,     phase_d;
    clk_time_t          disp_q,      disp_d;
    logic [MASK_W-1:0]  mask_q,      mask_d;
    logic               tick_q,      tick_d;
    logic               up_c;

    key_edge_detect u_key_edge_detect (
        .clk     (clk),
        .key     (bus.key),
        .press_c (press_c)
    );

    assign unused_key = press_c[K_RESERVED];
    assign up_c       = press_c[K_UP];

    // Next-state: key priority CANCEL > MODE > UP > DOWN, one action per cycle.
    always_comb begin
        mode_d      = mode_q;
        live_d      = live_q;
        edit_d      = edit_q;
        sec_cnt_d   = sec_cnt_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        tick_d      = 1'b0;

        if (mode_q == MODE_RUN) begin
            if (press_c[K_CANCEL]) begin
                mode_d = MODE_RUN;
            end else if (press_c[K_MODE]) begin
                mode_d      = MODE_SET_HOUR;
                edit_d      = live_q;
                sec_cnt_d   = '0;
                blink_cnt_d = '0;
                phase_d     = 1'b0;
            end else if (sec_cnt_q == CNT_W'(T1S - 1)) begin
                sec_cnt_d = '0;
                live_d    = time_inc(live_q);
                tick_d    = 1'b1;
            end else begin
                sec_cnt_d = sec_cnt_q + CNT_W'(1);
            end
        end else begin
            if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end

            if (press_c[K_CANCEL]) begin
                mode_d      = MODE_RUN;
                sec_cnt_d   = '0;
                blink_cnt_d = '0;
                phase_d     = 1'b0;
            end else if (press_c[K_MODE]) begin
                case (mode_q)
                    MODE_SET_HOUR: mode_d = MODE_SET_MIN;
                    MODE_SET_MIN:  mode_d = MODE_SET_SEC;
                    default: begin
                        mode_d    = MODE_RUN;
                        live_d    = edit_q;
                        sec_cnt_d = '0;
                    end
                endcase
                blink_cnt_d = '0;
                phase_d     = 1'b0;
            end else if (press_c[K_UP] || press_c[K_DOWN]) begin
                case (mode_q)
                    MODE_SET_HOUR: edit_d.hour = HOUR_W'(wrap_step(MINSEC_W'(edit_q.hour),
                                                                   MINSEC_W'(HOUR_MAX), up_c));
                    MODE_SET_MIN:  edit_d.min  = wrap_step(edit_q.min, MINSEC_W'(MINSEC_MAX), up_c);
                    default:       edit_d.sec  = wrap_step(edit_q.sec, MINSEC_W'(MINSEC_MAX), up_c);
                endcase
                blink_cnt_d = '0;
                phase_d     = 1'b0;
            end
        end

        disp_d = (mode_d == MODE_RUN) ? live_d : edit_d;
        mask_d = (mode_d != MODE_RUN && phase_d) ? field_mask(mode_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q      <= MODE_RUN;
            live_q      <= '0;
            edit_q      <= '0;
            sec_cnt_q   <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            disp_q      <= '0;
            mask_q      <= '0;
            tick_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            live_q      <= live_d;
            edit_q      <= edit_d;
            sec_cnt_q   <= sec_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            disp_q      <= disp_d;
            mask_q      <= mask_d;
            tick_q      <= tick_d;
        end
    end

    assign bus.hour_o     = disp_q.hour;
    assign bus.min_o      = disp_q.min;
    assign bus.sec_o      = disp_q.sec;
    assign bus.blink_mask = mask_q;
    assign bus.mode_o     = mode_q;
    assign bus.tick_o     = tick_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with a seconds-of-day reference model.
module tb_clock_set_ctrl;

    localparam int unsigned T1S       = 10;
    localparam int unsigned BLINK_DIV = 4;
    localparam logic [4:0]  KM = 5'b00001;
    localparam logic [4:0]  KU = 5'b00010;
    localparam logic [4:0]  KD = 5'b00100;
    localparam logic [4:0]  KC = 5'b01000;

    logic clk;
    logic rst;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(.T1S(T1S), .BLINK_DIV(BLINK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: live time as seconds of day, edit fields as plain integers.
    int         m_mode, m_live, m_eh, m_em, m_es, m_cnt, m_bcnt;
    bit         m_phase, m_tick;
    logic [4:0] m_prev;

    function void m_reset(input logic [4:0] k);
        m_mode = 0; m_live = 0; m_eh = 0; m_em = 0; m_es = 0;
        m_cnt = 0; m_bcnt = 0; m_phase = 0; m_tick = 0; m_prev = k;
    endfunction

    function void m_step(input logic [4:0] k);
        logic [4:0] p;
        int d;
        p      = k & ~m_prev;
        m_prev = k;
        m_tick = 0;
        if (m_mode == 0) begin
            if (!p[3]) begin
                if (p[0]) begin
                    m_mode = 1;
                    m_eh = m_live / 3600; m_em = (m_live / 60) % 60; m_es = m_live % 60;
                    m_cnt = 0; m_bcnt = 0; m_phase = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == T1S) begin
                        m_cnt = 0; m_live = (m_live + 1) % 86400; m_tick = 1;
                    end
                end
            end
        end else begin
            m_bcnt++;
            if (m_bcnt == BLINK_DIV) begin
                m_bcnt = 0; m_phase = !m_phase;
            end
            if (p[3]) begin
                m_mode = 0; m_cnt = 0; m_bcnt = 0; m_phase = 0;
            end else if (p[0]) begin
                if (m_mode == 3) begin
                    m_live = m_eh * 3600 + m_em * 60 + m_es;
                    m_mode = 0; m_cnt = 0;
                end else begin
                    m_mode++;
                end
                m_bcnt = 0; m_phase = 0;
            end else if (p[1] || p[2]) begin
                d = p[1] ? 1 : -1;
                case (m_mode)
                    1:       m_eh = (m_eh + 24 + d) % 24;
                    2:       m_em = (m_em + 60 + d) % 60;
                    default: m_es = (m_es + 60 + d) % 60;
                endcase
                m_bcnt = 0; m_phase = 0;
            end
        end
    endfunction

    function logic [27:0] m_expect();
        int h, m, s;
        logic [7:0] mk;
        if (m_mode == 0) begin
            h = m_live / 3600; m = (m_live / 60) % 60; s = m_live % 60;
        end else begin
            h = m_eh; m = m_em; s = m_es;
        end
        mk = 8'h00;
        if (m_mode != 0 && m_phase) mk = (m_mode == 1) ? 8'hC0 : (m_mode == 2) ? 8'h18 : 8'h03;
        return {5'(h), 6'(m), 6'(s), mk, 2'(m_mode), m_tick};
    endfunction

    function logic [27:0] dut_vec();
        return {bus.hour_o, bus.min_o, bus.sec_o, bus.blink_mask, bus.mode_o, bus.tick_o};
    endfunction

    task step(input logic [4:0] k);
        bus.key = k;
        @(posedge clk);
        m_step(k);
        @(negedge clk);
    endtask

    task rst_step(input logic [4:0] k);
        rst     = 1'b0;
        bus.key = k;
        @(posedge clk);
        m_reset(k);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task press(input logic [4:0] k);
        step(k);
        step(5'b0);
    endtask

    task test_reset();
        logic [4:0] k;
        k = 5'($urandom) | KM;
        rst_step(k);
        rst_step(k);
        checks++;
        if (dut_vec() !== 28'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 28'd0);
        end
        step(k);
        checks++;
        if (dut_vec() !== m_expect() || bus.mode_o !== 2'd0) begin
            errors++; $display("FAIL reset_held_key: got %h expected %h", dut_vec(), m_expect());
        end
        step(5'b0);
    endtask

    task test_run_600();
        int ticks;
        rst_step(5'b0);
        ticks = 0;
        for (int i = 1; i <= 600; i++) begin
            step(5'b0);
            checks++;
            if (bus.tick_o !== ((i % 10) == 0)) begin
                errors++; $display("FAIL run_tick cycle %0d: got %b expected %b", i, bus.tick_o, (i % 10) == 0);
            end
            if (bus.tick_o === 1'b1) ticks++;
        end
        checks++;
        if ({bus.hour_o, bus.min_o, bus.sec_o} !== {5'd0, 6'd1, 6'd0}) begin
            errors++; $display("FAIL run_time_600: got %0d:%0d:%0d expected 0:1:0", bus.hour_o, bus.min_o, bus.sec_o);
        end
        checks++;
        if (ticks != 60) begin
            errors++; $display("FAIL run_tick_count: got %0d expected 60", ticks);
        end
    endtask

    task test_wrap();
        rst_step(5'b0);
        press(KM); press(KD); press(KM); press(KD); press(KM); press(KD);
        step(KM);
        checks++;
        if (dut_vec() !== {5'd23, 6'd59, 6'd59, 8'h00, 2'd0, 1'b0}) begin
            errors++; $display("FAIL wrap_preload: got %h expected 23:59:59 RUN", dut_vec());
        end
        for (int i = 1; i <= 10; i++) begin
            step(5'b0);
            checks++;
            if (dut_vec() !== m_expect()) begin
                errors++; $display("FAIL wrap_cycle %0d: got %h expected %h", i, dut_vec(), m_expect());
            end
        end
        checks++;
        if (dut_vec() !== {5'd0, 6'd0, 6'd0, 8'h00, 2'd0, 1'b1}) begin
            errors++; $display("FAIL wrap_midnight: got %h expected 00:00:00 tick", dut_vec());
        end
    endtask

    task test_edit_sequence();
        logic [1:0] modes [4];
        modes = '{2'd1, 2'd2, 2'd3, 2'd0};
        rst_step(5'b0);
        step(KM);
        checks++;
        if (bus.mode_o !== modes[0]) begin
            errors++; $display("FAIL seq_mode0: got %0d expected %0d", bus.mode_o, modes[0]);
        end
        step(5'b0);
        press(KD);
        step(KM);
        checks++;
        if (bus.mode_o !== modes[1]) begin
            errors++; $display("FAIL seq_mode1: got %0d expected %0d", bus.mode_o, modes[1]);
        end
        step(5'b0);
        for (int i = 0; i < 61; i++) begin
            press(KU);
            checks++;
            if (dut_vec() !== m_expect()) begin
                errors++; $display("FAIL seq_up %0d: got %h expected %h", i, dut_vec(), m_expect());
            end
        end
        for (int j = 2; j < 4; j++) begin
            step(KM);
            checks++;
            if (bus.mode_o !== modes[j]) begin
                errors++; $display("FAIL seq_mode%0d: got %0d expected %0d", j, bus.mode_o, modes[j]);
            end
            step(5'b0);
        end
        checks++;
        if ({bus.hour_o, bus.min_o, bus.sec_o} !== {5'd23, 6'd1, 6'd0}) begin
            errors++; $display("FAIL seq_commit: got %0d:%0d:%0d expected 23:1:0", bus.hour_o, bus.min_o, bus.sec_o);
        end
    endtask

    task test_simultaneous();
        rst_step(5'b0);
        press(KM); press(KM); press(KU);
        step(KM | KU);
        checks++;
        if (bus.mode_o !== 2'd3 || bus.min_o !== 6'd1) begin
            errors++; $display("FAIL simul_mode_up: got mode %0d min %0d expected mode 3 min 1", bus.mode_o, bus.min_o);
        end
        step(5'b0);
        step(KC | KM);
        checks++;
        if (dut_vec() !== 28'd0) begin
            errors++; $display("FAIL simul_cancel_mode: got %h expected %h", dut_vec(), 28'd0);
        end
        step(5'b0);
        step(KC | KM);
        checks++;
        if (dut_vec() !== m_expect() || bus.mode_o !== 2'd0) begin
            errors++; $display("FAIL simul_run_cancel: got %h expected %h", dut_vec(), m_expect());
        end
        step(5'b0);
        step(KU | KD);
        checks++;
        if (dut_vec() !== m_expect() || bus.mode_o !== 2'd0) begin
            errors++; $display("FAIL simul_run_updown: got %h expected %h", dut_vec(), m_expect());
        end
        step(5'b0);
    endtask

    task test_blink();
        logic [7:0] exp_m;
        rst_step(5'b0);
        step(KM);
        checks++;
        if (bus.blink_mask !== 8'h00) begin
            errors++; $display("FAIL blink_enter: got %h expected 00", bus.blink_mask);
        end
        for (int i = 1; i <= 16; i++) begin
            step(5'b0);
            exp_m = (((i / 4) % 2) == 1) ? 8'hC0 : 8'h00;
            checks++;
            if (bus.blink_mask !== exp_m || dut_vec() !== m_expect()) begin
                errors++; $display("FAIL blink_idle %0d: got %h expected %h", i, bus.blink_mask, exp_m);
            end
        end
        step(KU);
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) step(5'b0);
            exp_m = (i == 4) ? 8'hC0 : 8'h00;
            checks++;
            if (bus.blink_mask !== exp_m || bus.hour_o !== 5'd1) begin
                errors++; $display("FAIL blink_after_up %0d: got %h hour %0d expected %h hour 1", i, bus.blink_mask, bus.hour_o, exp_m);
            end
        end
    endtask

    task test_reset_mid();
        rst_step(5'b0);
        press(KM); press(KU); press(KM); press(KD); press(KM); press(KD);
        checks++;
        if (bus.mode_o !== 2'd3 || bus.sec_o !== 6'd59) begin
            errors++; $display("FAIL mid_setup: got mode %0d sec %0d expected mode 3 sec 59", bus.mode_o, bus.sec_o);
        end
        rst_step(KM);
        rst_step(KM);
        for (int i = 0; i < 5; i++) begin
            step(KM);
            checks++;
            if (dut_vec() !== m_expect() || bus.mode_o !== 2'd0 || bus.hour_o !== 5'd0) begin
                errors++; $display("FAIL mid_held %0d: got %h expected %h", i, dut_vec(), m_expect());
            end
        end
        step(5'b0);
        step(KM);
        checks++;
        if (dut_vec() !== {5'd0, 6'd0, 6'd0, 8'h00, 2'd1, 1'b0}) begin
            errors++; $display("FAIL mid_repress: got %h expected SET_HOUR 00:00:00", dut_vec());
        end
    endtask

    task test_random();
        logic [4:0] k;
        rst_step(5'b0);
        k = 5'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) k = 5'($urandom);
            if ($urandom_range(0, 299) == 0) rst_step(k);
            else step(k);
            checks++;
            if (dut_vec() !== m_expect()) begin
                errors++; $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec(), m_expect());
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        bus.key = 5'b0;
        m_reset(5'b0);
        test_reset();
        test_run_600();
        test_wrap();
        test_edit_sequence();
        test_simultaneous();
        test_blink();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-keeping and time-setting controller for the 8-digit seven-segment clock.
- Owns the live hours/minutes/seconds registers and the 1 s tick.
- Sequences a RUN/SET state machine driven by five debounced key levels.
- Feeds the display-scan block with the time to show and a per-digit blink mask.
- Sits between the board keys and the display scan/segment decoder.

Parameters:
T1S, 100000000, clk cycles per second tick (100 MHz clock)
BLINK_DIV, 50000000, clk cycles per blink-phase toggle (0.5 s)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-low
key  in  5  debounced key levels, 1 = pressed; [0]=MODE [1]=UP [2]=DOWN [3]=CANCEL [4]=unused/reserved
hour_o  out  5  hours to display, 0..23
min_o  out  6  minutes to display, 0..59
sec_o  out  6  seconds to display, 0..59
blink_mask  out  8  1 = blank this digit; bit7 = leftmost digit
mode_o  out  2  0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
tick_o  out  1  one-cycle pulse when live time advances

Behaviour:
- Reset (rst=0 at posedge clk):
  - live and edit time = 00:00:00; state RUN; second counter 0; blink phase 0.
  - All outputs 0.
  - prev_key <= key, so a key held through reset gives no edge.
- Key edge: press = key[i] & ~prev_key[i], evaluated each cycle; prev_key <= key every cycle.
  - Action registered at the same edge that first samples the key high; outputs change after that edge.
- Simultaneous presses: priority CANCEL > MODE > UP > DOWN. Only the winner acts; the other edges in that cycle are discarded.
- Second counter (RUN only):
  - Counts 0..T1S-1. At T1S-1 it wraps to 0 and live time increments with carry: sec 59->0 carries to min, min 59->0 carries to hour, hour 23->0.
  - tick_o = 1 for exactly the cycle in which the new time is first visible.
- FSM:
  - RUN --MODE--> SET_HOUR: edit <= live; counter held at 0; live time frozen.
  - SET_HOUR --MODE--> SET_MIN --MODE--> SET_SEC.
  - SET_SEC --MODE--> RUN: live <= edit, counter <= 0; the next tick arrives T1S cycles later.
  - Any SET state --CANCEL--> RUN: edit discarded, live unchanged, counter resumes from 0.
  - CANCEL in RUN: no effect.
- UP/DOWN in a SET state change only the active edit field, modulo:
  - hour: 23 UP -> 0, 0 DOWN -> 23
  - min/sec: 59 UP -> 0, 0 DOWN -> 59
  - UP/DOWN in RUN: ignored.
- Displayed time: hour_o/min_o/sec_o = live in RUN, edit in SET states. Registered; updates the cycle after the causing edge.
- Blink:
  - Phase counter runs only in SET states; phase toggles every BLINK_DIV cycles.
  - Phase and counter clear to 0 on entering any SET state, on field change, and on UP/DOWN, so the field is visible immediately after an edit.
  - blink_mask = field mask when phase=1, else 0. Field masks: hour 8'b11000000, min 8'b00011000, sec 8'b00000011.
  - Separator digits (bits 5, 2) never blink. blink_mask = 0 in RUN.
- Reset mid-operation: any state returns to RUN with 00:00:00; uncommitted edits are lost.

Decomposition:
- Package clock_pkg holds:
  - mode encoding (RUN, SET_HOUR, SET_MIN, SET_SEC)
  - key index constants (K_MODE=0, K_UP=1, K_DOWN=2, K_CANCEL=3)
  - field blink masks
  - HOUR_MAX=23, MINSEC_MAX=59
- One sub-module, key_edge_detect: prev-key register with reset-load, producing 5-bit press pulses.
- FSM, counters and time registers stay in clock_set_ctrl.

Test Plan:
All tests use T1S=10, BLINK_DIV=4.
1. Reset, run 600 cycles -> tick_o every 10 cycles; time 00:01:00 at cycle 600; tick count 60.
2. Preload 23:59:59 via SET sequence, commit -> after 10 cycles time 00:00:00 and tick_o=1 that cycle.
3. MODE, DOWN, MODE, UP x61, MODE, MODE -> committed 23:01:00; mode_o steps 1,2,3,0.
4. In SET_MIN: MODE and UP pressed the same cycle -> state SET_SEC, min unchanged. CANCEL+MODE together -> RUN, live unchanged.
5. In SET_HOUR, hold keys idle 16 cycles -> blink_mask alternates 0/8'hC0 every 4 cycles starting 0. UP press -> mask 0 for the next 4 cycles.
6. rst=0 while in SET_SEC with MODE held, release rst -> RUN, 00:00:00, no state change until MODE is released and re-pressed.
